// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: sequences each instruction through fetch/decode/execute/memory/writeback
// and drives datapath controls, with a wait-state data-bus handshake, a bus timeout and sticky error flags.
module multicycle_control_unit #(
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        irEn,
    output logic        pcEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [1:0]  RFWDSrcMuxSel,
    output logic        busWe,
    output logic        busRe,
    output logic        branch,
    output logic        RD1MuxSel,
    output logic        Jump,
    output logic        illegalInstr,
    output logic        busTimeout,
    output logic [3:0]  stateDbg
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  R_EXE  = 4'd2,  I_EXE  = 4'd3,
        B_EXE  = 4'd4,  LU_EXE = 4'd5,  AU_EXE = 4'd6,  J_EXE  = 4'd7,
        JL_EXE = 4'd8,  S_EXE  = 4'd9,  S_MEM  = 4'd10, L_EXE  = 4'd11,
        L_MEM  = 4'd12, L_WB   = 4'd13, ERROR  = 4'd14
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LU   = 7'b0110111;
    localparam logic [6:0] OP_AU   = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam bit             TIMEOUT_EN  = (BUS_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(BUS_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             tout_q, tout_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       unused_instr_bits;

    assign opcode = instrCode[6:0];
    assign funct3 = instrCode[14:12];
    assign bit30  = instrCode[30];
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    logic       ir_c, pc_c, we_c, src_c, bwe_c, bre_c, br_c, rd1_c, j_c;
    logic [3:0] alu_c;
    logic [1:0] wd_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            tout_q    <= tout_d;
        end
    end

    // Bus handshake: busWe/busRe are held for the whole MEM state; the access completes in the
    // first cycle busReady is seen high. busReady is a don't-care in every other state.
    // The wait counter defaults to zero so it clears on every MEM entry and exit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        tout_d    = tout_q;
        ir_c = 1'b0; pc_c = 1'b0; we_c = 1'b0; src_c = 1'b0;
        bwe_c = 1'b0; bre_c = 1'b0; br_c = 1'b0; rd1_c = 1'b0; j_c = 1'b0;
        alu_c = 4'b0000;
        wd_c  = 2'b00;
        unique case (state_q)
            FETCH: begin
                ir_c    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                unique case (opcode)
                    OP_R:    state_d = R_EXE;
                    OP_L:    state_d = L_EXE;
                    OP_I:    state_d = I_EXE;
                    OP_S:    state_d = S_EXE;
                    OP_B:    state_d = B_EXE;
                    OP_LU:   state_d = LU_EXE;
                    OP_AU:   state_d = AU_EXE;
                    OP_JAL:  state_d = J_EXE;
                    OP_JALR: state_d = JL_EXE;
                    default: begin
                        state_d   = ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            R_EXE: begin
                pc_c = 1'b1; we_c = 1'b1; alu_c = {bit30, funct3}; state_d = FETCH;
            end
            I_EXE: begin
                pc_c = 1'b1; we_c = 1'b1; src_c = 1'b1; state_d = FETCH;
                // Only the shift-right immediates carry an op bit in instr[30]; elsewhere it is immediate data.
                alu_c = (funct3 == 3'b101) ? {bit30, 3'b101} : {1'b0, funct3};
            end
            B_EXE: begin
                pc_c = 1'b1; br_c = 1'b1; alu_c = {1'b0, funct3}; state_d = FETCH;
            end
            LU_EXE: begin
                pc_c = 1'b1; we_c = 1'b1; src_c = 1'b1; rd1_c = 1'b1; state_d = FETCH;
            end
            AU_EXE: begin
                pc_c = 1'b1; we_c = 1'b1; wd_c = 2'b10; state_d = FETCH;
            end
            J_EXE: begin
                pc_c = 1'b1; we_c = 1'b1; wd_c = 2'b11; j_c = 1'b1; state_d = FETCH;
            end
            JL_EXE: begin
                pc_c = 1'b1; we_c = 1'b1; wd_c = 2'b11; src_c = 1'b1; state_d = FETCH;
            end
            S_EXE: begin
                src_c = 1'b1; state_d = S_MEM;
            end
            S_MEM: begin
                src_c = 1'b1; bwe_c = 1'b1;
                if (busReady) begin
                    pc_c    = 1'b1;
                    state_d = FETCH;
                end else if (TIMEOUT_EN && cnt_q == TIMEOUT_LIM) begin
                    state_d = ERROR;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            L_EXE: begin
                src_c = 1'b1; state_d = L_MEM;
            end
            L_MEM: begin
                src_c = 1'b1; bre_c = 1'b1;
                if (busReady) begin
                    state_d = L_WB;
                end else if (TIMEOUT_EN && cnt_q == TIMEOUT_LIM) begin
                    state_d = ERROR;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            L_WB: begin
                pc_c = 1'b1; we_c = 1'b1; wd_c = 2'b01; src_c = 1'b1; state_d = FETCH;
            end
            ERROR: state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    // Gate with reset_n so every output is low for as long as reset is held, not just after the edge.
    assign irEn          = reset_n & ir_c;
    assign pcEn          = reset_n & pc_c;
    assign regFileWe     = reset_n & we_c;
    assign aluControl    = reset_n ? alu_c : 4'b0000;
    assign aluSrcMuxSel  = reset_n & src_c;
    assign RFWDSrcMuxSel = reset_n ? wd_c : 2'b00;
    assign busWe         = reset_n & bwe_c;
    assign busRe         = reset_n & bre_c;
    assign branch        = reset_n & br_c;
    assign RD1MuxSel     = reset_n & rd1_c;
    assign Jump          = reset_n & j_c;
    assign illegalInstr  = reset_n & illegal_q;
    assign busTimeout    = reset_n & tout_q;
    assign stateDbg      = reset_n ? 4'(state_q) : 4'b0000;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle RV32I control unit; next generation after the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states. Drives the same datapath controls plus instruction-register and PC enables.
- Adds wait-state data-bus handshake, bus timeout, and illegal-opcode detection with a sticky error state.
- Sits between the instruction register / data bus and the existing datapath muxes and ALU.

Parameters:
- BUS_TIMEOUT, 16: max wait cycles in a MEM state before error; 0 disables timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > BUS_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instrCode  in  32  instruction held in IR; stable from DECODE to end of instruction
- busReady  in  1  data-bus access complete this cycle
- irEn  out  1  load IR (asserted in FETCH)
- pcEn  out  1  update PC (last cycle of each instruction)
- regFileWe  out  1  register-file write enable
- aluControl  out  4  ALU operation
- aluSrcMuxSel  out  1  0=RD2, 1=immediate
- RFWDSrcMuxSel  out  2  00=ALU, 01=bus rdata, 10=PC+imm, 11=PC+4
- busWe  out  1  data-bus write request
- busRe  out  1  data-bus read request
- branch  out  1  branch-compare qualify for PC mux
- RD1MuxSel  out  1  1=zero to ALU A (LUI)
- Jump  out  1  JAL target select
- illegalInstr  out  1  sticky: unknown opcode decoded
- busTimeout  out  1  sticky: bus wait exceeded BUS_TIMEOUT
- stateDbg  out  4  current state encoding

Behaviour:
- Opcodes: R 0110011, L 0000011, I 0010011, S 0100011, B 1100011, LU 0110111, AU 0010111, JAL 1101111, JALR 1100111.
- States: FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, ERROR.
- Reset (async, reset_n=0): state=FETCH, wait counter=0, illegalInstr=0, busTimeout=0. All outputs 0 while in reset.
- Outputs are combinational from the current state and instrCode. Every output not listed for a state is 0, and aluControl defaults to 4'b0000.
- FETCH: irEn=1; next state DECODE.
- DECODE: no enables. Next state by opcode to the matching *_EXE state. Unknown opcode goes to ERROR and sets illegalInstr.
- Latency in cycles from FETCH entry to the pcEn cycle inclusive:
  - R, I, B, LU, AU, JAL, JALR: 3
  - S: 4 + wait cycles
  - L: 5 + wait cycles
- Single-cycle EXE states all assert pcEn=1 and return to FETCH:
  - R_EXE: regFileWe=1; aluControl={instr[30],funct3}.
  - I_EXE: regFileWe=1, aluSrcMuxSel=1. aluControl={instr[30],101} if funct3=101, else {0,funct3}.
  - B_EXE: branch=1; aluControl={0,funct3}.
  - LU_EXE: regFileWe=1, aluSrcMuxSel=1, RD1MuxSel=1.
  - AU_EXE: regFileWe=1, RFWDSrcMuxSel=10.
  - J_EXE: regFileWe=1, RFWDSrcMuxSel=11, Jump=1.
  - JL_EXE: regFileWe=1, RFWDSrcMuxSel=11, aluSrcMuxSel=1.
- Store path:
  - S_EXE: aluSrcMuxSel=1 (address compute); go to S_MEM.
  - S_MEM: aluSrcMuxSel=1, busWe=1. If busReady: pcEn=1, go to FETCH. Otherwise stay and increment the wait counter.
- Load path:
  - L_EXE: aluSrcMuxSel=1; go to L_MEM.
  - L_MEM: aluSrcMuxSel=1, busRe=1. If busReady, go to L_WB; otherwise stay and count.
  - L_WB: regFileWe=1, RFWDSrcMuxSel=01, aluSrcMuxSel=1, pcEn=1; go to FETCH.
- Wait counter:
  - Cleared on every MEM-state entry and exit.
  - busReady in the first MEM cycle means zero wait.
  - If BUS_TIMEOUT>0 and the counter equals BUS_TIMEOUT while busReady=0, go to ERROR and set busTimeout. This happens after BUS_TIMEOUT+1 MEM cycles.
  - busReady sampled in the same cycle the counter hits the limit has priority: the access completes and no timeout fires.
- ERROR: all enables 0 and sticky flags held. Leaves only on reset_n.
- busReady outside MEM states is ignored.
- Reset asserted mid-instruction aborts immediately; no partial writes occur after reset.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset → FETCH(irEn=1), DECODE, R_EXE with regFileWe=1, aluControl=0000, pcEn=1; back in FETCH at cycle 4.
- srai x5,x5,3 (0x4032D293) → I_EXE aluControl=1101, aluSrcMuxSel=1; addi with bit30 set via imm (0x40028293) → aluControl=0000.
- lw x4,8(x0) (0x00802203), busReady held low 2 cycles → L_MEM 3 cycles busRe=1, then L_WB with RFWDSrcMuxSel=01, regFileWe=1, pcEn=1; total 7 cycles.
- sw with BUS_TIMEOUT=4, busReady never high → busWe=1 for 5 cycles, then ERROR with busTimeout=1; enables stay 0 for 10+ cycles.
- sw with BUS_TIMEOUT=4, busReady rises in the 5th S_MEM cycle → completes with pcEn=1, busTimeout=0.
- Opcode 0x7F → ERROR with illegalInstr=1. reset_n pulsed mid L_MEM → outputs 0 asynchronously; FETCH on release; flags cleared.
